// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the card-side SD DAT responder.
package sd_dat_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RX_WAIT   = 4'd1,
    ST_RX_SHIFT  = 4'd2,
    ST_RX_CHECK  = 4'd3,
    ST_TOK_GAP   = 4'd4,
    ST_TOK_SEND  = 4'd5,
    ST_BUSY_HOLD = 4'd6,
    ST_BUSY_END  = 4'd7,
    ST_TX_WAIT   = 4'd8,
    ST_TX_SHIFT  = 4'd9
  } state_t;

  localparam int FRAME_LEN = 50;
  localparam int DATA_BITS = 32;
  localparam int CRC_BITS  = 16;

  localparam logic [2:0]  TOKEN_OK  = 3'b010;
  localparam logic [2:0]  TOKEN_BAD = 3'b101;
  localparam logic [15:0] CRC_POLY  = 16'h1021;

  // One serial step of CRC16-CCITT, MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    if (fb) begin
      return {crc[14:0], 1'b0} ^ CRC_POLY;
    end else begin
      return {crc[14:0], 1'b0};
    end
  endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT register, shared by the receive and transmit paths.
module sd_crc16_serial
  import sd_dat_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  // CRC accumulator; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc <= 16'h0000;
    end else if (clear) begin
      crc <= 16'h0000;
    end else if (enable) begin
      crc <= crc16_step(crc, bit_in);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/sd_card_dat_responder.sv
// Card-side single-bit SD DAT endpoint: receives write frames, returns token/busy, sends read frames.
// Define SD_DAT_CRC_EN to generate and check the frame CRC; otherwise the CRC field is zero / ignored.
module sd_card_dat_responder
  import sd_dat_pkg::*;
#(
  parameter int BUSY_CYCLES = 8,
  parameter int NAC_CYCLES  = 2,
  parameter int RX_TIMEOUT  = 64
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        start_write,
  input  logic        start_read,
  input  logic        stop,
  input  logic [3:0]  blocks,
  input  logic        dat_in,
  output logic        dat_out,
  output logic        dat_oe,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        done,
  output logic        crc_error,
  output logic        timeout,
  output logic        busy
);

  localparam logic [15:0] RX_LAST   = 16'(RX_TIMEOUT - 1);
  localparam logic [15:0] BUSY_LAST = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] NAC_LAST  = 16'((NAC_CYCLES > 0) ? NAC_CYCLES - 1 : 0);
  localparam logic [15:0] RX_END    = 16'(FRAME_LEN - 2);
  localparam logic [15:0] TX_END    = 16'(FRAME_LEN - 1);
  localparam logic [15:0] DATA_END  = 16'(DATA_BITS);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  blk, blk_n;
  logic [47:0] rx_shift, rx_shift_n;
  logic [31:0] tx_word, tx_word_n;
  logic        tok_ok, tok_ok_n;
  logic [31:0] rx_data_n;
  logic        rx_valid_n, done_n, crc_error_n, timeout_n;
  logic        oe_n, out_n, ready_n, busy_n;
  logic        tx_bit_n;
  logic [2:0]  tok;
  logic [5:0]  cb;
  logic [4:0]  di;
  logic [3:0]  ci;
  logic [15:0] crc_val;
  logic        crc_ok;

`ifdef SD_DAT_CRC_EN
  logic crc_clear, crc_en, crc_bit;

  // CRC feed: received data bits while shifting in, outgoing data bits as they are launched.
  always_comb begin
    crc_clear = (state == ST_IDLE) || (state == ST_RX_WAIT) || (state == ST_TX_WAIT);
    crc_en    = 1'b0;
    crc_bit   = 1'b0;
    if ((state == ST_RX_SHIFT) && (cnt < DATA_END)) begin
      crc_en  = 1'b1;
      crc_bit = dat_in;
    end else if ((state_n == ST_TX_SHIFT) && (cnt_n >= 16'd1) && (cnt_n <= DATA_END)) begin
      crc_en  = 1'b1;
      crc_bit = tx_bit_n;
    end else begin
      crc_en  = 1'b0;
      crc_bit = 1'b0;
    end
  end

  sd_crc16_serial u_crc (
    .clk    (sd_clock),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .bit_in (crc_bit),
    .crc    (crc_val)
  );

  assign crc_ok = (crc_val == rx_shift[15:0]);
`else
  assign crc_val = 16'h0000;
  assign crc_ok  = 1'b1;
`endif

  // Next-state, counters and per-frame results.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    blk_n       = blk;
    rx_shift_n  = rx_shift;
    tx_word_n   = tx_word;
    tok_ok_n    = tok_ok;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    done_n      = 1'b0;
    crc_error_n = crc_error;
    timeout_n   = timeout;
    if (stop) begin
      state_n = ST_IDLE;
      cnt_n   = 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_write || start_read) begin
            crc_error_n = 1'b0;
            timeout_n   = 1'b0;
            blk_n       = blocks;
            cnt_n       = 16'd0;
            if (blocks == 4'd0) begin
              done_n = 1'b1;
            end else if (start_write) begin
              state_n = ST_RX_WAIT;
            end else begin
              state_n = ST_TX_WAIT;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_RX_WAIT: begin
          if (!dat_in) begin
            state_n = ST_RX_SHIFT;
            cnt_n   = 16'd0;
          end else if (cnt == RX_LAST) begin
            timeout_n = 1'b1;
            done_n    = 1'b1;
            state_n   = ST_IDLE;
            cnt_n     = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        ST_RX_SHIFT: begin
          rx_shift_n = {rx_shift[46:0], dat_in};
          if (cnt == RX_END) begin
            // dat_in is the end bit here; rx_shift still holds data and CRC.
            state_n = ST_RX_CHECK;
            cnt_n   = 16'd0;
            if (dat_in && crc_ok) begin
              tok_ok_n   = 1'b1;
              rx_valid_n = 1'b1;
              rx_data_n  = rx_shift[47:16];
            end else begin
              tok_ok_n    = 1'b0;
              crc_error_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        ST_RX_CHECK: begin
          state_n = ST_TOK_GAP;
          cnt_n   = 16'd0;
        end
        ST_TOK_GAP: begin
          if (cnt == 16'd1) begin
            state_n = ST_TOK_SEND;
            cnt_n   = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        ST_TOK_SEND: begin
          if (cnt == 16'd2) begin
            state_n = ST_BUSY_HOLD;
            cnt_n   = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        ST_BUSY_HOLD: begin
          if (cnt == BUSY_LAST) begin
            state_n = ST_BUSY_END;
            cnt_n   = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        ST_BUSY_END: begin
          blk_n = blk - 4'd1;
          cnt_n = 16'd0;
          if (blk == 4'd1) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_RX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          if (tx_ready && tx_valid) begin
            state_n   = ST_TX_SHIFT;
            cnt_n     = 16'd0;
            tx_word_n = tx_data;
          end else if (cnt < NAC_LAST) begin
            cnt_n = cnt + 16'd1;
          end else begin
            cnt_n = cnt;
          end
        end
        ST_TX_SHIFT: begin
          if (cnt == TX_END) begin
            blk_n = blk - 4'd1;
            cnt_n = 16'd0;
            if (blk == 4'd1) begin
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end else begin
              state_n = ST_TX_WAIT;
            end
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = 16'd0;
        end
      endcase
    end
  end

  // Read-frame bit at the index being launched: start, data, CRC, end.
  always_comb begin
    cb = cnt_n[5:0];
    di = 5'(6'd32 - cb);
    ci = 4'(6'd48 - cb);
    if (cb == 6'd0) begin
      tx_bit_n = 1'b0;
    end else if (cb <= 6'd32) begin
      tx_bit_n = tx_word_n[di];
    end else if (cb <= 6'd48) begin
      tx_bit_n = crc_val[ci];
    end else begin
      tx_bit_n = 1'b1;
    end
  end

  // Pad drive and status derived from the state being entered, so outputs register in step.
  always_comb begin
    oe_n    = 1'b0;
    out_n   = 1'b1;
    tok     = tok_ok_n ? TOKEN_OK : TOKEN_BAD;
    ready_n = (state_n == ST_TX_WAIT) && (cnt_n >= NAC_LAST);
    busy_n  = (state_n != ST_IDLE);
    case (state_n)
      ST_TOK_SEND: begin
        oe_n  = 1'b1;
        out_n = tok[2'd2 - cnt_n[1:0]];
      end
      ST_BUSY_HOLD: begin
        oe_n  = 1'b1;
        out_n = 1'b0;
      end
      ST_BUSY_END: begin
        oe_n  = 1'b1;
        out_n = 1'b1;
      end
      ST_TX_SHIFT: begin
        oe_n  = 1'b1;
        out_n = tx_bit_n;
      end
      default: begin
        oe_n  = 1'b0;
        out_n = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 16'd0;
      blk       <= 4'd0;
      rx_shift  <= 48'd0;
      tx_word   <= 32'd0;
      tok_ok    <= 1'b0;
      rx_data   <= 32'd0;
      rx_valid  <= 1'b0;
      done      <= 1'b0;
      crc_error <= 1'b0;
      timeout   <= 1'b0;
      dat_oe    <= 1'b0;
      dat_out   <= 1'b1;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      blk       <= blk_n;
      rx_shift  <= rx_shift_n;
      tx_word   <= tx_word_n;
      tok_ok    <= tok_ok_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      done      <= done_n;
      crc_error <= crc_error_n;
      timeout   <= timeout_n;
      dat_oe    <= oe_n;
      dat_out   <= out_n;
      tx_ready  <= ready_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_sd_card_dat_responder.sv
// Self-checking bench for sd_card_dat_responder: directed sequence with randomized data,
// expectations derived from frame/timing rules (CRC expectations follow SD_DAT_CRC_EN).
module tb_sd_card_dat_responder;

  localparam int BC  = 8;
  localparam int NAC = 2;
  localparam int RXT = 64;

  logic        clk = 1'b0;
  logic        reset, start_write, start_read, stop;
  logic [3:0]  blocks;
  logic        dat_in, dat_out, dat_oe;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready, done, crc_error, timeout, busy;

  int          errors = 0;
  int          checks = 0;
  logic        exp_crc_err = 1'b0;
  logic [31:0] last_rx = 32'd0;
  logic [31:0] words [4];
  int          stall [4];

  sd_card_dat_responder #(.BUSY_CYCLES(BC), .NAC_CYCLES(NAC), .RX_TIMEOUT(RXT)) dut (
    .sd_clock(clk), .reset(reset), .start_write(start_write), .start_read(start_read),
    .stop(stop), .blocks(blocks), .dat_in(dat_in), .dat_out(dat_out), .dat_oe(dat_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .done(done), .crc_error(crc_error), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_crc(input logic [31:0] d);
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [49:0] model_tx_frame(input logic [31:0] d);
`ifdef SD_DAT_CRC_EN
    return {1'b0, d, model_crc(d), 1'b1};
`else
    return {1'b0, d, 16'h0000, 1'b1};
`endif
  endfunction

  // Expected {oe,out} k cycles after the RX_CHECK cycle of a write frame.
  function automatic logic [1:0] exp_line(input int k, input logic good);
    logic [2:0] t;
    t = good ? 3'b010 : 3'b101;
    if (k <= 2)            return 2'b01;
    else if (k <= 5)       return {1'b1, t[5-k]};
    else if (k <= 5 + BC)  return 2'b10;
    else if (k == 6 + BC)  return 2'b11;
    else                   return 2'b01;
  endfunction

  task automatic start_xfer(input logic w, input logic r, input logic [3:0] n);
    start_write = w; start_read = r; blocks = n;
    tick();
    start_write = 1'b0; start_read = 1'b0;
    exp_crc_err = 1'b0;
  endtask

  task automatic write_frame(input logic [31:0] d, input logic end_bit, input logic flip,
                             input logic last, input int gap);
    logic [49:0] fr;
    logic [1:0]  e;
    logic        good;
    int          bad;
    fr = {1'b0, d, model_crc(d), end_bit};
    if (flip) fr[1 + $urandom_range(0, 15)] ^= 1'b1;
`ifdef SD_DAT_CRC_EN
    good = end_bit && !flip;
`else
    good = end_bit;
`endif
    bad = 0;
    dat_in = 1'b1;
    for (int g = 0; g < gap; g++) begin
      tick();
      if (dat_oe !== 1'b0 || busy !== 1'b1) bad++;
    end
    for (int i = 0; i < 50; i++) begin
      dat_in = fr[49-i];
      tick();
      if (i < 49 && (dat_oe !== 1'b0 || rx_valid !== 1'b0)) bad++;
    end
    dat_in = 1'b1;
    check("rx_line_released", bad, 0);
    if (good) last_rx = d;
    else      exp_crc_err = 1'b1;
    check("rx_valid", rx_valid, good);
    check("rx_data", rx_data, last_rx);
    check("crc_error", crc_error, exp_crc_err);
    for (int k = 1; k <= 6 + BC; k++) begin
      tick();
      e = exp_line(k, good);
      check("wr_resp_oe", dat_oe, e[1]);
      if (e[1]) check("wr_resp_out", dat_out, e[0]);
    end
    tick();
    check("wr_done", done, last);
    check("wr_busy_after", busy, !last);
    check("wr_released_after", dat_oe, 0);
  endtask

  task automatic read_xfer(input int n, input logic [31:0] w [4], input int st [4]);
    logic [49:0] got, fr;
    int          c, exp_hs, oebad;
    logic        hs;
    start_xfer(1'b0, 1'b1, 4'(n));
    check("rd_crc_error_cleared", crc_error, 0);
    for (int b = 0; b < n; b++) begin
      hs = 1'b0; c = 0; oebad = 0;
      while (!hs && c < 100) begin
        c++;
        tx_valid = (c > st[b]);
        tx_data  = w[b];
        check("tx_ready", tx_ready, (c >= NAC));
        if (dat_oe !== 1'b0) oebad++;
        hs = tx_valid && tx_ready;
        tick();
      end
      tx_valid = 1'b0;
      exp_hs = (NAC > st[b] + 1) ? NAC : st[b] + 1;
      check("rd_handshake_cycle", c, exp_hs);
      check("rd_gap_released", oebad, 0);
      check("tx_ready_drop", tx_ready, 0);
      fr = model_tx_frame(w[b]);
      got = '0; oebad = 0;
      for (int i = 0; i < 50; i++) begin
        got[49-i] = dat_out;
        if (dat_oe !== 1'b1) oebad++;
        tick();
      end
      check("rd_frame", got, fr);
      check("rd_frame_oe", oebad, 0);
      check("rd_oe_fall", dat_oe, 0);
      check("rd_done", done, (b == n - 1));
      check("rd_busy_after", busy, (b != n - 1));
    end
  endtask

  initial begin
    int   n, badi, c, bad;
    logic [49:0] fr;
    reset = 1'b1; start_write = 1'b0; start_read = 1'b0; stop = 1'b0;
    blocks = 4'd0; dat_in = 1'b1; tx_data = 32'd0; tx_valid = 1'b0;
    tick(); tick(); tick();
    check("rst_dat_oe", dat_oe, 0);
    check("rst_dat_out", dat_out, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_crc_error", crc_error, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rx_data", rx_data, 0);
    reset = 1'b0;
    tick();

    // single good write
    start_xfer(1'b1, 1'b0, 4'd1);
    check("wr_busy", busy, 1);
    write_frame(32'hA5A5_0F0F, 1'b1, 1'b0, 1'b1, 2);

    // bad end bit
    start_xfer(1'b1, 1'b0, 4'd1);
    write_frame($urandom, 1'b0, 1'b0, 1'b1, 1);
`ifdef SD_DAT_CRC_EN
    start_xfer(1'b1, 1'b0, 4'd1);
    write_frame($urandom, 1'b1, 1'b1, 1'b1, 0);
`endif

    // multi-block write with one rejected frame; crc_error stays sticky
    n = 3;
    badi = $urandom_range(0, n - 1);
    start_xfer(1'b1, 1'b0, 4'(n));
    for (int b = 0; b < n; b++)
      write_frame($urandom, (b != badi), 1'b0, (b == n - 1), $urandom_range(0, 5));

    // read, two blocks, tx_valid held
    words[0] = 32'h0000_0000; words[1] = 32'hDEAD_BEEF; words[2] = 32'd0; words[3] = 32'd0;
    for (int i = 0; i < 4; i++) stall[i] = 0;
    read_xfer(2, words, stall);

    // randomized read
    n = $urandom_range(1, 4);
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom;
      stall[i] = $urandom_range(0, 4);
    end
    read_xfer(n, words, stall);

    // start-bit timeout
    start_xfer(1'b1, 1'b0, 4'd1);
    dat_in = 1'b1;
    for (int i = 1; i < RXT; i++) tick();
    check("to_not_yet", timeout, 0);
    check("to_busy_before", busy, 1);
    tick();
    check("to_timeout", timeout, 1);
    check("to_done", done, 1);
    check("to_idle", busy, 0);
    tick();
    check("to_done_pulse", done, 0);

    // stop in the middle of a read frame
    start_xfer(1'b0, 1'b1, 4'd2);
    check("start_clears_timeout", timeout, 0);
    tx_data = $urandom; tx_valid = 1'b1; c = 0;
    while (tx_ready !== 1'b1 && c < 50) begin
      tick(); c++;
    end
    check("stop_ready_seen", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("stop_pre_oe", dat_oe, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_oe", dat_oe, 0);
    check("stop_busy", busy, 0);
    bad = (done !== 1'b0) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done !== 1'b0 || dat_oe !== 1'b0) bad++;
    end
    check("stop_no_done", bad, 0);
    words[0] = $urandom; stall[0] = 1;
    read_xfer(1, words, stall);

    // simultaneous starts with zero blocks
    start_xfer(1'b1, 1'b1, 4'd0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_oe", dat_oe, 0);
    tick();
    check("zero_done_pulse", done, 0);
    check("zero_oe_after", dat_oe, 0);

    // simultaneous starts with one block: write wins
    start_xfer(1'b1, 1'b1, 4'd1);
    check("both_ready_low", tx_ready, 0);
    write_frame($urandom, 1'b1, 1'b0, 1'b1, 3);

    // stop on the end bit suppresses rx_valid and done
    start_xfer(1'b1, 1'b0, 4'd1);
    fr = {1'b0, 32'h1234_5678, model_crc(32'h1234_5678), 1'b1};
    for (int i = 0; i < 49; i++) begin
      dat_in = fr[49-i];
      tick();
    end
    dat_in = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_rx_valid", rx_valid, 0);
    check("stop_rx_done", done, 0);
    check("stop_rx_busy", busy, 0);
    tick();
    check("stop_rx_valid_after", rx_valid, 0);
    check("stop_rx_data_kept", rx_data, last_rx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_card_dat_responder.md
# sd_card_dat_responder

Card-side endpoint of the single-bit SD DAT line, facing the host-side data PHY across the pad. For writes it receives 50-bit block frames from the host, checks them, returns a 3-bit status token, then holds busy. For reads it serialises 32-bit words from card storage into 50-bit frames. It is the card model for the host data path, and the building block for a card-emulation top.

## Interface
Parameters:
- BUSY_CYCLES, 8: cycles DAT is held low after a status token.
- NAC_CYCLES, 2: released-line cycles between read start (or a previous read frame) and the next start bit.
- RX_TIMEOUT, 64: cycles to wait for a write start bit before flagging a timeout.

Ports (one clock; reset is synchronous and active-high):
- sd_clock  in  1  sole clock; everything samples and launches on its rising edge.
- reset  in  1  synchronous, active-high.
- start_write  in  1  pulse: arm reception of `blocks` frames.
- start_read  in  1  pulse: transmit `blocks` frames.
- stop  in  1  abort the current transfer.
- blocks  in  4  block count, latched on start; 0 means no transfer.
- dat_in  in  1  sampled DAT line from the pad.
- dat_out  out  1  value driven on DAT.
- dat_oe  out  1  pad drive enable; 0 means the line is released.
- rx_data  out  32  received word, valid with rx_valid.
- rx_valid  out  1  one-cycle pulse for each accepted frame.
- tx_data  in  32  word to send.
- tx_valid  in  1  tx_data is available.
- tx_ready  out  1  word is taken on the cycle where tx_valid && tx_ready.
- done  out  1  one-cycle pulse at the end of the transfer.
- crc_error  out  1  sticky; set on any rejected frame.
- timeout  out  1  sticky; set on a start-bit timeout.
- busy  out  1  high whenever the state is not IDLE.

## Operation
Frame format (50 bits, MSB first), identical in both directions:
- 1 start bit, value 0.
- 32 data bits.
- 16 CRC bits.
- 1 end bit, value 1.

States:
- IDLE
- RX_WAIT: wait for the write start bit.
- RX_SHIFT: shift in the rest of the write frame.
- RX_CHECK: judge the received frame.
- TOK_GAP: released gap before the token.
- TOK_SEND: drive the status token.
- BUSY_HOLD: hold DAT low.
- BUSY_END: drive the line high for one cycle.
- TX_WAIT: wait for a read word and NAC.
- TX_SHIFT: drive the read frame.

Starting a transfer:
- IDLE with start_write → RX_WAIT. IDLE with start_read → TX_WAIT. In both cases blocks is latched into the remaining-block counter.
- start_write and start_read together: the write wins and the read is ignored.
- Starts outside IDLE are ignored.
- blocks == 0: done pulses the next cycle, the state stays IDLE, the line is untouched.

Write path:
- RX_WAIT: the first dat_in == 0 is the start bit → RX_SHIFT, which samples 49 bits.
- If RX_TIMEOUT cycles pass with no start bit: set timeout, pulse done, return to IDLE.
- RX_CHECK: the frame is good when end bit == 1 and (if enabled) the CRC matches.
  - Good: rx_valid pulses with rx_data.
  - Bad: crc_error is set and rx_valid stays low.
- TOK_GAP lasts 2 cycles with the line released.
- TOK_SEND drives 3 bits: 3'b010 accepted, 3'b101 rejected.
- BUSY_HOLD drives 0 for BUSY_CYCLES. BUSY_END drives 1 for one cycle, then the line is released.
- The counter then decrements. If it is nonzero → RX_WAIT; if zero → done, IDLE.

Read path:
- TX_WAIT keeps the line released for at least NAC_CYCLES.
- After that, tx_ready is high and the state waits on tx_valid indefinitely.
- Handshake → TX_SHIFT, which drives 50 bits with dat_oe = 1.
- The counter then decrements. If it is nonzero → TX_WAIT, with NAC counted afresh; if zero → done, IDLE.

stop, in any state: the next state is IDLE and dat_oe = 0 at that edge. No done pulse; rx_valid is suppressed. reset mid-frame behaves the same.

CRC: CRC16-CCITT (x^16+x^12+x^5+1), initial value 0, computed over the 32 data bits only.

## Timing
- Reset values:
  - dat_oe = 0, dat_out = 1.
  - rx_valid, tx_ready, done, busy = 0.
  - crc_error, timeout = 0.
  - rx_data = 0; state IDLE.
- Sticky crc_error and timeout clear only on reset or on an accepted start.
- Write: start bit sampled at cycle S.
  - End bit at S+49.
  - rx_valid at S+50 (RX_CHECK).
  - Token bits at S+53..S+55.
  - Busy low at S+56..S+55+BUSY_CYCLES, then a high cycle.
- Read: start accepted at cycle T.
  - Earliest handshake at T+NAC_CYCLES.
  - Start bit driven the cycle after the handshake, end bit 49 cycles later.
  - dat_oe falls the cycle after the end bit.
- tx_ready is high only in TX_WAIT once NAC has elapsed; it drops the cycle after the handshake.
- done is asserted for one cycle, coincident with the return to IDLE.

## Configuration
- SD_DAT_CRC_EN defined: a sd_crc16_serial instance generates and checks the CRC.
- Not defined:
  - The transmitted CRC field is 16'h0000.
  - The received CRC field is ignored; only the end bit is checked.
  - This matches the host PHY's fixed zero CRC.

## Structure
- sd_dat_pkg holds:
  - the state enum;
  - FRAME_LEN = 50, DATA_BITS = 32, CRC_BITS = 16;
  - TOKEN_OK = 3'b010, TOKEN_BAD = 3'b101;
  - CRC_POLY = 16'h1021.
- Sub-module sd_crc16_serial: clear / enable / bit in, 16-bit crc out. It is shared by the RX and TX paths, because only one path is active at a time.

## Test plan
- Write, blocks = 1, frame 0 + 32'hA5A5_0F0F + correct CRC + 1 → rx_valid with 32'hA5A5_0F0F at S+50, token 010, BUSY_CYCLES lows, done.
- Write, end bit 0 (and, with CRC_EN, one flipped CRC bit) → no rx_valid, crc_error = 1, token 101.
- Read, blocks = 2, tx_valid held with 32'h0000_0000 then 32'hDEAD_BEEF → two frames of 50 bits, CRC 16'h0000 on the first, released gap ≥ NAC between them, done after the second.
- Write armed, DAT held 1 for 64 cycles → timeout = 1, done, IDLE.
- stop asserted mid-TX_SHIFT → dat_oe = 0 next edge, no done; a subsequent start_read works normally.
- start_write and start_read together with blocks = 0 → done the next cycle, dat_oe never asserted.
